// File: rtl/gnn_mac_sched.sv
// gnn_mac_sched: time-multiplexed GNN node evaluator (4 features -> 4 hidden
// -> 2 outputs) built around one shared 5x5-bit signed multiply-accumulate.
// Layer 1 takes 16 cycles and layer 2 takes 8. The result is then held until
// the consumer accepts it.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   w_we/w_addr/w_data  weight write port, honoured only in IDLE
//                       (0..15 -> w1[i][j] at i*4+j, 16..23 -> w2[j][k] at
//                       16+j*2+k, 24..31 ignored)
//   in_valid/in_ready   node input handshake; in_x packs x0..x3 (5-bit
//                       signed each, x0 in [4:0]); in_node is the tag
//   out_valid/out_ready result handshake; out0/out1 are 21-bit signed and
//                       out_node is the tag returned with them
//   busy                high while a node is being evaluated or held
//
// Build option: define GNN_RELU_EN to clamp hidden values at zero (ReLU).
module gnn_mac_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        w_we,
    input  logic [4:0]  w_addr,
    input  logic [4:0]  w_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_x,
    input  logic [1:0]  in_node,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [20:0] out0,
    output logic [20:0] out1,
    output logic [1:0]  out_node,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, L1, L2, OUT} state_t;
    state_t state, state_nx;

    logic [4:0]  w1 [16];
    logic [4:0]  w2 [8];
    logic [4:0]  x  [4];
    logic [11:0] h  [4];
    logic [1:0]  node;
    logic [3:0]  cnt;
    logic [18:0] acc;

    logic [11:0] mac_a;
    logic [4:0]  mac_b;
    logic [16:0] prod;
    logic [18:0] sum;
    logic [11:0] h_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = L1;
            end
            L1: begin
                busy = 1'b1;
                if (cnt == 4'd15) state_nx = L2;
            end
            L2: begin
                busy = 1'b1;
                if (cnt[2:0] == 3'd7) state_nx = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand select for the shared MAC. L1: c = {j,i}, weight index i*4+j.
    // L2: c = {k,j}, weight index j*2+k.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        case (state)
            L1: begin
                mac_a = {{7{x[cnt[1:0]][4]}}, x[cnt[1:0]]};
                mac_b = w1[{cnt[1:0], cnt[3:2]}];
            end
            L2: begin
                mac_a = h[cnt[1:0]];
                mac_b = w2[{cnt[1:0], cnt[2]}];
            end
            default: ;
        endcase
    end

    // True products always fit in 17 bits, so truncating the 17x17 product is exact.
    assign prod = $signed({{5{mac_a[11]}}, mac_a}) * $signed({{12{mac_b[4]}}, mac_b});
    assign sum  = acc + {{2{prod[16]}}, prod};

    always_comb begin
`ifdef GNN_RELU_EN
        h_new = sum[18] ? '0 : sum[11:0];
`else
        h_new = sum[11:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w1       <= '{default: '0};
            w2       <= '{default: '0};
            x        <= '{default: '0};
            h        <= '{default: '0};
            node     <= '0;
            cnt      <= '0;
            acc      <= '0;
            out0     <= '0;
            out1     <= '0;
            out_node <= '0;
        end else begin
            if (state == IDLE && w_we) begin
                if (!w_addr[4])     w1[w_addr[3:0]] <= w_data;
                else if (!w_addr[3]) w2[w_addr[2:0]] <= w_data;
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x[0] <= in_x[4:0];
                        x[1] <= in_x[9:5];
                        x[2] <= in_x[14:10];
                        x[3] <= in_x[19:15];
                        node <= in_node;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                L1: begin
                    // Wraps 15 -> 0, which is exactly the L2 start count.
                    cnt <= cnt + 4'd1;
                    if (cnt[1:0] == 2'd3) begin
                        h[cnt[3:2]] <= h_new;
                        acc         <= '0;
                    end else begin
                        acc <= sum;
                    end
                end
                L2: begin
                    cnt <= cnt + 4'd1;
                    if (cnt[1:0] == 2'd3) begin
                        if (cnt[2]) begin
                            out1     <= {{2{sum[18]}}, sum};
                            out_node <= node;
                        end else begin
                            out0 <= {{2{sum[18]}}, sum};
                        end
                        acc <= '0;
                    end else begin
                        acc <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_mac_sched.sv
// Testbench for gnn_mac_sched: table of uniform-weight vectors, hand-written
// corner sequences (index mapping, write+accept, backpressure, abort) and
// randomized nodes checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_gnn_mac_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        w_we = 1'b0;
    logic [4:0]  w_addr = '0;
    logic [4:0]  w_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_x = '0;
    logic [1:0]  in_node = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [20:0] out0, out1;
    logic [1:0]  out_node;
    logic        busy;

    gnn_mac_sched dut (
        .clk(clk), .rst_n(rst_n),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_node(in_node),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out_node(out_node), .busy(busy)
    );

    always #5 clk = ~clk;

`ifdef GNN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int tw1 [16];
    int tw2 [8];
    int tx  [4];

    typedef struct {
        int w1v;
        int w2v;
        int xv;
        int e0;
        int e1;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(output int e0, output int e1);
        int hh [4];
        for (int j = 0; j < 4; j++) begin
            hh[j] = 0;
            for (int i = 0; i < 4; i++) hh[j] += tx[i] * tw1[i*4 + j];
            if (RELU && hh[j] < 0) hh[j] = 0;
        end
        e0 = 0;
        e1 = 0;
        for (int j = 0; j < 4; j++) begin
            e0 += hh[j] * tw2[j*2];
            e1 += hh[j] * tw2[j*2 + 1];
        end
    endfunction

    task automatic wr(input int addr, input int data);
        @(negedge clk);
        w_we   = 1'b1;
        w_addr = addr[4:0];
        w_data = data[4:0];
        @(posedge clk);
        #1;
        w_we = 1'b0;
    endtask

    task automatic write_all();
        for (int n = 0; n < 16; n++) wr(n, tw1[n]);
        for (int n = 0; n < 8; n++) wr(16 + n, tw2[n]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out0", $signed(out0), 0);
        check("rst_out1", $signed(out1), 0);
        check("rst_out_node", out_node, 0);
    endtask

    task automatic start_node(input int node, input bit do_w, input int wa, input int wd);
        @(negedge clk);
        check("pre_accept_in_ready", in_ready, 1);
        in_x     = {tx[3][4:0], tx[2][4:0], tx[1][4:0], tx[0][4:0]};
        in_node  = node[1:0];
        in_valid = 1'b1;
        w_we     = do_w;
        w_addr   = wa[4:0];
        w_data   = wd[4:0];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        w_we     = 1'b0;
        check("post_accept_in_ready", in_ready, 0);
        check("post_accept_busy", busy, 1);
    endtask

    task automatic wait_result(input string name, input int node, input int e0, input int e1);
        int lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, lat, 24);
        check({name, "_out0"}, $signed(out0), e0);
        check({name, "_out1"}, $signed(out1), e1);
        check({name, "_out_node"}, out_node, node);
    endtask

    task automatic handshake(input int hold);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
    endtask

    initial begin
        int e0, e1;
        logic [20:0] held0;

        tbl[0] = '{w1v: 15,  w2v: 15,  xv: 15,  e0: 54000,  e1: 54000};
        tbl[1] = '{w1v: -16, w2v: -16, xv: -16, e0: -65536, e1: -65536};
        tbl[2] = '{w1v: -1,  w2v: 1,   xv: 1,   e0: RELU ? 0 : -16, e1: RELU ? 0 : -16};
        tbl[3] = '{w1v: 1,   w2v: 1,   xv: 1,   e0: 16,     e1: 16};
        tbl[4] = '{w1v: 2,   w2v: -3,  xv: 1,   e0: -96,    e1: -96};
        tbl[5] = '{w1v: 1,   w2v: -1,  xv: -2,  e0: RELU ? 0 : 32, e1: RELU ? 0 : 32};
        tbl[6] = '{w1v: 7,   w2v: -5,  xv: 3,   e0: -1680,  e1: -1680};

        do_reset();

        // Unwritten weights give zero results.
        tx = '{7, -3, 11, -16};
        start_node(1, 1'b0, 0, 0);
        wait_result("zero_w", 1, 0, 0);
        handshake(0);

        // Index mapping; writes to 24 and 26 must not alias into w2.
        wr(9, 3);
        wr(18, 2);
        wr(26, -5);
        wr(24, 7);
        tx = '{0, 0, 5, 0};
        start_node(2, 1'b0, 0, 0);
        wait_result("index_map", 2, 30, 0);
        handshake(0);

        // Write on the accepting edge is used by that node.
        start_node(3, 1'b1, 9, 6);
        wait_result("write_accept", 3, 60, 0);
        handshake(0);

        // Backpressure: outputs hold, input and writes ignored.
        wr(9, 3);
        start_node(2, 1'b0, 0, 0);
        wait_result("bp", 2, 30, 0);
        held0 = out0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = 20'($urandom);
            w_we     = 1'b1;
            w_addr   = 5'd9;
            w_data   = 5'h19;
            @(posedge clk);
            #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_out0_held", $signed(out0), $signed(held0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        w_we     = 1'b0;
        handshake(0);
        start_node(0, 1'b0, 0, 0);
        wait_result("bp_rerun", 0, 30, 0);
        handshake(0);

        // Uniform-weight vector table.
        for (int v = 0; v < 7; v++) begin
            for (int n = 0; n < 16; n++) tw1[n] = tbl[v].w1v;
            for (int n = 0; n < 8; n++) tw2[n] = tbl[v].w2v;
            for (int n = 0; n < 4; n++) tx[n] = tbl[v].xv;
            write_all();
            start_node(v % 4, 1'b0, 0, 0);
            wait_result("table", v % 4, tbl[v].e0, tbl[v].e1);
            handshake(0);
        end

        // Randomized nodes against the reference model.
        for (int r = 0; r < 20; r++) begin
            int tag;
            for (int n = 0; n < 16; n++) tw1[n] = int'($urandom_range(31, 0)) - 16;
            for (int n = 0; n < 8; n++) tw2[n] = int'($urandom_range(31, 0)) - 16;
            for (int n = 0; n < 4; n++) tx[n] = int'($urandom_range(31, 0)) - 16;
            tag = int'($urandom_range(3, 0));
            write_all();
            model(e0, e1);
            start_node(tag, 1'b0, 0, 0);
            wait_result("random", tag, e0, e1);
            handshake(int'($urandom_range(3, 0)));
        end

        // Reset mid-L1 aborts the node and clears weights.
        tx = '{15, 15, 15, 15};
        start_node(1, 1'b0, 0, 0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out0", $signed(out0), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_node(1, 1'b0, 0, 0);
        wait_result("abort_rerun", 1, 0, 0);
        handshake(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
